// File: rtl/cpu_pkg.sv
// Shared CPU core types: instruction/PC widths, opcode constants,
// fetch FSM states and the fetch buffer entry layout.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {inst, pc} pairs between instruction memory and decode.
// Clear wins over push; the head reads as all-zero while empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    fetch_entry_t  mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !clear && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && count_q == '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALTED control, one-outstanding-read credit
// issue to synchronous instruction memory, and a buffered valid/ready output.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [5:0]        opecode,
    output logic [5:0]        funct,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] issued_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   fifo_count;
    logic [OW-1:0]   outstanding;
    logic            credit_ok;
    logic            pop;
    logic            push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop  = inst_valid & inst_ready;
    assign push = inflight_q & ~redirect;

    // Words already buffered plus the one in flight must leave room after this cycle's pop.
    assign outstanding = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
    assign credit_ok   = outstanding < OW'(DEPTH);
    assign imem_en     = rstn & (state_q == RUN) & ~redirect & credit_ok;
    assign imem_addr   = pc_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN:     if (halt && !redirect) state_d = HALTED;
            HALTED:  if (redirect) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (redirect) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (imem_en) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_en;
            if (imem_en) issued_pc_q <= pc_q;
        end
    end

    assign push_entry.inst = imem_rdata;
    assign push_entry.pc   = issued_pc_q;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .clear    (redirect),
        .count    (fifo_count),
        .head     (head)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign opecode    = head.inst[31:26];
    assign funct      = head.inst[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opecode;
    logic [5:0]  funct;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .opecode    (opecode),
        .funct      (funct),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Instruction memory: word content equals its address, one cycle read latency.
    always @(posedge clk) imem_rdata <= imem_en ? imem_addr : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered words, the single pending read, the PC and a halt flag.
    fetch_entry_t m_fifo[$];
    logic [31:0]  m_acc[$];
    logic [31:0]  d_acc[$];
    logic         m_halted = 1'b0;
    logic [31:0]  m_pc = RST_PC;
    logic         m_pend = 1'b0;
    logic [31:0]  m_pend_pc = 32'h0;

    function automatic logic m_pop();
        return (m_fifo.size() != 0) && inst_ready;
    endfunction

    function automatic logic m_en();
        int words_owed;
        words_owed = m_fifo.size() + int'(m_pend) - int'(m_pop());
        return rstn && !m_halted && !redirect && (words_owed < DEPTH);
    endfunction

    always @(posedge clk or negedge rstn) begin
        logic         pop_now;
        logic         en_now;
        fetch_entry_t e;
        if (!rstn) begin
            m_fifo.delete();
            m_halted = 1'b0;
            m_pc     = RST_PC;
            m_pend   = 1'b0;
        end else begin
            pop_now = m_pop();
            en_now  = m_en();
            if (pop_now) begin
                m_acc.push_back(m_fifo[0].pc);
                void'(m_fifo.pop_front());
            end
            if (redirect) begin
                m_fifo.delete();
                m_pend   = 1'b0;
                m_pc     = redirect_pc & 32'hFFFF_FFFC;
                m_halted = 1'b0;
            end else begin
                if (m_pend) begin
                    e.inst = m_pend_pc;
                    e.pc   = m_pend_pc;
                    m_fifo.push_back(e);
                end
                m_pend = en_now;
                if (en_now) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
                if (halt) m_halted = 1'b1;
            end
        end
    end

    // Compare process: inputs change on the falling edge, outputs are checked 2 units later.
    always @(negedge clk) begin
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        #2;
        e_inst = (m_fifo.size() != 0) ? m_fifo[0].inst : 32'h0;
        e_pc   = (m_fifo.size() != 0) ? m_fifo[0].pc   : 32'h0;
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_fifo.size() != 0});
        check("inst", inst, e_inst);
        check("inst_pc", inst_pc, e_pc);
        check("opecode", {26'b0, opecode}, {26'b0, e_inst[31:26]});
        check("funct", {26'b0, funct}, {26'b0, e_inst[5:0]});
        check("imem_en", {31'b0, imem_en}, {31'b0, m_en()});
        check("imem_addr", imem_addr, m_pc);
        check("fifo_count", 32'(u_dut.fifo_count), m_fifo.size());
        if (inst_valid && inst_ready) d_acc.push_back(inst_pc);
    end

    task automatic cyc(input logic rs, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic hlt);
        @(negedge clk);
        rstn        = rs;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hlt;
        #3;
    endtask

    initial begin
        int hits;
        // Reset state
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("rst imem_en", {31'b0, imem_en}, 0);
        check("rst inst_valid", {31'b0, inst_valid}, 0);
        check("rst inst", inst, 0);
        check("rst inst_pc", inst_pc, 0);
        check("rst opecode", {26'b0, opecode}, 0);

        // First fetches and streaming with no bubbles
        cyc(1, 1, 0, 0, 0);
        check("c0 imem_en", {31'b0, imem_en}, 1);
        check("c0 imem_addr", imem_addr, 32'h100);
        check("c0 inst_valid", {31'b0, inst_valid}, 0);
        cyc(1, 1, 0, 0, 0);
        check("c1 imem_addr", imem_addr, 32'h104);
        check("c1 inst_valid", {31'b0, inst_valid}, 0);
        cyc(1, 1, 0, 0, 0);
        check("c2 imem_addr", imem_addr, 32'h108);
        check("c2 inst", inst, 32'h100);
        for (int k = 3; k <= 6; k++) begin
            cyc(1, 1, 0, 0, 0);
            check("stream valid", {31'b0, inst_valid}, 1);
            check("stream inst", inst, 32'h100 + 32'(4 * (k - 2)));
            check("stream addr", imem_addr, 32'h100 + 32'(4 * k));
        end

        // Asynchronous reset in mid-stream
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("async rst imem_en", {31'b0, imem_en}, 0);
        check("async rst inst_valid", {31'b0, inst_valid}, 0);
        cyc(0, 0, 0, 0, 0);

        // Backpressure from reset
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0, 0);
        check("bp count", 32'(u_dut.fifo_count), 2);
        check("bp imem_en", {31'b0, imem_en}, 0);
        check("bp inst_pc", inst_pc, 32'h100);
        cyc(1, 1, 0, 0, 0);
        check("release pc0", inst_pc, 32'h100);
        cyc(1, 1, 0, 0, 0);
        check("release pc1", inst_pc, 32'h104);
        cyc(1, 1, 0, 0, 0);
        check("release pc2", inst_pc, 32'h108);
        cyc(1, 1, 0, 0, 0);

        // Redirect to an unaligned target
        cyc(1, 1, 1, 32'h203, 0);
        check("redir T imem_en", {31'b0, imem_en}, 0);
        cyc(1, 1, 0, 0, 0);
        check("redir T+1 imem_en", {31'b0, imem_en}, 1);
        check("redir T+1 addr", imem_addr, 32'h200);
        check("redir T+1 valid", {31'b0, inst_valid}, 0);
        cyc(1, 1, 0, 0, 0);
        check("redir T+2 valid", {31'b0, inst_valid}, 0);
        cyc(1, 1, 0, 0, 0);
        check("redir T+3 valid", {31'b0, inst_valid}, 1);
        check("redir T+3 inst_pc", inst_pc, 32'h200);
        cyc(1, 1, 0, 0, 0);

        // Redirect in the same cycle as a pop of a full FIFO
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h1000, 0);
        check("rpop head", inst_pc, 32'h208);
        cyc(1, 1, 0, 0, 0);
        check("rpop T+1 count", 32'(u_dut.fifo_count), 0);
        check("rpop T+1 addr", imem_addr, 32'h1000);
        cyc(1, 1, 0, 0, 0);

        // Halt: outstanding word still delivered, FIFO drains, no new fetches
        cyc(1, 1, 0, 0, 1);
        check("halt T imem_en", {31'b0, imem_en}, 1);
        check("halt T inst_pc", inst_pc, 32'h1000);
        cyc(1, 1, 0, 0, 0);
        check("halt T+1 imem_en", {31'b0, imem_en}, 0);
        check("halt T+1 inst_pc", inst_pc, 32'h1004);
        cyc(1, 1, 0, 0, 1);
        check("halt T+2 inst_pc", inst_pc, 32'h1008);
        cyc(1, 1, 0, 0, 0);
        check("halt T+3 valid", {31'b0, inst_valid}, 0);
        check("halt T+3 imem_en", {31'b0, imem_en}, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 32'h40, 0);
        check("unhalt T imem_en", {31'b0, imem_en}, 0);
        cyc(1, 1, 0, 0, 0);
        check("unhalt T+1 imem_en", {31'b0, imem_en}, 1);
        check("unhalt T+1 addr", imem_addr, 32'h40);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);

        // PC wrap at the top of the address space
        cyc(1, 1, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 1, 0, 0, 0);
        check("wrap T+1 addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 0);
        check("wrap T+2 addr", imem_addr, 32'h0);
        cyc(1, 1, 0, 0, 0);
        check("wrap T+3 inst", inst, 32'hFFFF_FFFC);
        check("wrap T+3 opecode", {26'b0, opecode}, 32'h3F);
        check("wrap T+3 funct", {26'b0, funct}, 32'h3C);
        cyc(1, 1, 0, 0, 0);
        check("wrap T+4 inst_pc", inst_pc, 32'h0);
        for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0);

        @(posedge clk);
        #1;
        check("accepted count", d_acc.size(), m_acc.size());
        for (int i = 0; i < d_acc.size() && i < m_acc.size(); i++)
            check("accepted order", d_acc[i], m_acc[i]);
        hits = 0;
        foreach (d_acc[i]) if (d_acc[i] == 32'h208) hits++;
        check("redirect-pop accepted once", hits, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the CPU core. Holds the program counter, issues reads to the synchronous instruction memory, and buffers returned words in a small FIFO. It presents instructions to the controller/decode stage with a valid/ready handshake, splitting out `opecode` and `funct`. It also accepts PC redirects (jumps and branches) and halt requests from downstream.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, 2: instruction FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on posedge.
- `rstn` input 1: reset, asynchronous, active-low.
- `imem_en` output 1: read strobe to instruction memory.
- `imem_addr` output 32: byte address of the read, always word-aligned.
- `imem_rdata` input 32: read data, valid the cycle after `imem_en`.
- `inst_valid` output 1: FIFO head holds an instruction.
- `inst_ready` input 1: downstream accepts the head this cycle.
- `inst` output 32: head instruction word.
- `inst_pc` output 32: PC of the head instruction.
- `opecode` output 6: `inst[31:26]`.
- `funct` output 6: `inst[5:0]`.
- `redirect` input 1: load a new PC and flush.
- `redirect_pc` input 32: target PC; bits [1:0] are ignored and forced to 0.
- `halt` input 1: stop issuing fetches.

## Operation
**FSM states:** RUN (reset state) and HALTED.
- RUN goes to HALTED when `halt`=1 and `redirect`=0.
- HALTED goes to RUN on `redirect`.
- `halt` is ignored in HALTED.

**Registers:**
- `pc`: next fetch address.
- `inflight`: 1 bit; a read was issued last cycle.
- FIFO of {inst, pc} pairs, `DEPTH` entries, with occupancy `count`.

**Issue:**
- `imem_en = (state==RUN) & ~redirect & (count + inflight - pop < DEPTH)`, where `pop = inst_valid & inst_ready`.
- `imem_addr = pc`.
- On issue: `pc <= pc + 4` (32-bit wrap, 32'hFFFF_FFFC+4 = 0), `inflight <= 1`. Otherwise `inflight <= 0`.

**Return:**
- When `inflight`=1 and `redirect`=0, push {`imem_rdata`, issued PC} into the FIFO.
- The credit check guarantees the FIFO never overflows. The FIFO asserts on a push while full, or a pop while empty.

**Output:**
- `inst_valid = (count != 0)`.
- `inst`, `inst_pc`, `opecode`, `funct` are combinational from the FIFO head. They are 0 when the FIFO is empty.

**Redirect (highest priority):**
- A pop in the same cycle is still counted as accepted.
- Then the FIFO is cleared, and any return arriving this cycle is discarded.
- No issue occurs this cycle.
- `pc <= {redirect_pc[31:2], 2'b00}`, `inflight <= 0`.
- Redirect while HALTED loads the PC and returns the FSM to RUN.

**Halt:**
- An outstanding read still returns and is pushed.
- The FIFO keeps draining to downstream.

**Simultaneous push and pop:** `count` is unchanged and both occur.

## Timing
- **Reset values:** `pc`=`RESET_PC`, `count`=0, `inflight`=0, state RUN. Hence `imem_en`=0 while `rstn`=0, and `inst_valid`=0, `inst`/`inst_pc`/`opecode`/`funct`=0.
- **First fetch:** issued in the first cycle after `rstn` rises (cycle 0), at address `RESET_PC`. Data returns in cycle 1, and `inst_valid` first goes high in cycle 2.
- **Fetch-to-valid latency:** 2 cycles.
- **Throughput:** 1 instruction/cycle sustained with `inst_ready` held at 1 and `DEPTH` ≥ 2.
- **Redirect in cycle T:** fetch at target in T+1, `inst_valid` for the target in T+3. No stale instruction is visible in T+1 or later.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). Any memory data returning after reset is ignored, because `inflight`=0.

## Structure
- Package `cpu_pkg`:
  - `INST_W`=32, `PC_W`=32.
  - Opcode constants: R-type 6'b000000, `J` 6'b000010, `BEQ` 6'b000100, `BNE` 6'b000101, `ADDI` 6'b001000, `SLTI` 6'b001010, `ANDI` 6'b001100, `ORI` 6'b001101.
  - `fetch_state_t` enum {RUN, HALTED}.
  - `fetch_entry_t` struct {inst, pc}.
- Sub-module `fetch_fifo`:
  - Parameterised by `DEPTH`, synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, clear, count, head.
  - Its clear has priority over push.
- `fetch_unit` holds the PC, FSM, `inflight` and the issue logic.

## Test plan
- **Reset:** `RESET_PC`=32'h100, `inst_ready`=1, memory returns word = address.
  - Expect `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles.
  - Expect `inst` 0x100 in cycle 2, then one per cycle with no bubbles.
- **Backpressure:** hold `inst_ready`=0 for 10 cycles.
  - Expect `count` to saturate at 2 and `imem_en` to drop.
  - Release: expect `inst_pc` 0x100, 0x104, 0x108 in order, none lost or duplicated.
- **Redirect:** assert `redirect` in mid-stream with `redirect_pc`=32'h203.
  - Expect fetch of 0x200 in T+1 and `inst_pc`=0x200 in T+3.
  - Expect no old-PC instruction after T.
- **Redirect with pop:** assert `redirect` in the same cycle as `inst_ready`.
  - Expect the head counted as accepted exactly once and the FIFO empty in T+1.
- **Halt:** pulse `halt`.
  - Expect `imem_en`=0 afterward, the outstanding word delivered, the FIFO drained.
  - Then `redirect` to 0x40: expect RUN and fetch of 0x40.
- **Async reset and wrap:**
  - Assert `rstn` low mid-stream: expect `inst_valid`=0 and `imem_en`=0 immediately.
  - Redirect to 0xFFFF_FFFC: expect the next fetch at 0x0000_0000.
